clk_ratio_detect: RTL

Receive-side checker for power-of-two divided clocks. It samples a divided clock `div_clk_in`, which comes from a ripple or counter divider, in the reference `clk` domain. It measures the rising-edge period in `clk` cycles and reports the detected ratio as log2. It declares lock after consecutive matching periods and flags loss on mismatch or a stopped clock. It sits beside clock dividers as a bring-up and runtime monitor.

---
 rtl/clk_ratio_pkg.sv | 28 ++
 rtl/bit_sync.sv | 22 ++
 rtl/clk_ratio_detect.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clk_ratio_pkg.sv
// Shared types and helpers for the divided-clock ratio checker.
package clk_ratio_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} crd_state_t;

  localparam int unsigned DEF_MAX_LOG2 = 8;

  function automatic int unsigned cnt_w(input int unsigned max_log2);
    return max_log2 + 2;
  endfunction

  function automatic int unsigned ratio_w(input int unsigned max_log2);
    return $clog2(max_log2 + 1);
  endfunction

  function automatic logic is_pow2(input logic [31:0] value);
    return (value != '0) && ((value & (value - 32'd1)) == '0);
  endfunction

  function automatic logic [31:0] log2_of_pow2(input logic [31:0] value);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++)
      if (value[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, clearable synchronously.
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   chain <= '0;
    else if (clr) chain <= '0;
    else          chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clk_ratio_detect.sv
// Measures the rising-edge period of a divided clock, locks onto a stable
// power-of-two ratio and flags loss on mismatch or a stopped clock.
module clk_ratio_detect
  import clk_ratio_pkg::*;
#(
  parameter int unsigned MAX_LOG2    = DEF_MAX_LOG2,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           div_clk_in,
  input  logic                           clr,
  output logic [$clog2(MAX_LOG2+1)-1:0]  ratio_log2,
  output logic                           ratio_valid,
  output logic                           locked,
  output logic                           lost,
  output logic [MAX_LOG2+1:0]            period
);

  localparam int unsigned    CW     = cnt_w(MAX_LOG2);
  localparam int unsigned    RW     = ratio_w(MAX_LOG2);
  localparam int unsigned    MW     = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]  TMO    = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0]  P_MAX  = TMO >> 1;
  localparam logic [MW-1:0]  M_LOCK = MW'(LOCK_CNT);

  logic             synced, hist, edge_det;
  crd_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cand, cand_nxt, period_nxt;
  logic             cand_ok, cand_ok_nxt;
  logic [MW-1:0]    match, match_nxt, match_inc;
  logic [RW-1:0]    ratio_nxt;
  logic             valid_nxt, locked_nxt, lost_nxt;
  logic             p_legal, p_hit, tmo;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (clr),
    .d     (div_clk_in),
    .q     (synced)
  );

  assign edge_det  = synced & ~hist;
  assign p_legal   = (cnt >= CW'(2)) && (cnt <= P_MAX) && is_pow2(32'(cnt));
  assign p_hit     = cand_ok && (cnt == cand);
  assign tmo       = (cnt == TMO);
  assign match_inc = match + MW'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    cand_ok_nxt = cand_ok;
    match_nxt   = match;
    period_nxt  = period;
    ratio_nxt   = ratio_log2;
    valid_nxt   = ratio_valid;
    locked_nxt  = locked;
    lost_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (edge_det) begin
          state_nxt   = MEASURE;
          cnt_nxt     = CW'(1);
          cand_ok_nxt = 1'b0;
          match_nxt   = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (!tmo) cnt_nxt = cnt + CW'(1);
        // An edge coinciding with TMO is measured as P = TMO, which is illegal.
        if (edge_det) begin
          period_nxt = cnt;
          cnt_nxt    = CW'(1);
          if (!(state == LOCKED && p_hit)) begin
            if (state == LOCKED) begin
              lost_nxt   = 1'b1;
              locked_nxt = 1'b0;
              valid_nxt  = 1'b0;
              state_nxt  = MEASURE;
            end
            if (!p_legal) begin
              cand_ok_nxt = 1'b0;
              match_nxt   = '0;
            end else if (p_hit) begin
              match_nxt = match_inc;
            end else begin
              cand_nxt    = cnt;
              cand_ok_nxt = 1'b1;
              match_nxt   = MW'(1);
            end
            if (state == MEASURE && p_legal && match_nxt == M_LOCK) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
              valid_nxt  = 1'b1;
              ratio_nxt  = RW'(log2_of_pow2(32'(cnt)));
            end
          end
        end else if (tmo) begin
          state_nxt  = IDLE;
          period_nxt = TMO;
          lost_nxt   = (state == LOCKED);
          locked_nxt = 1'b0;
          valid_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hist        <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      cand_ok     <= 1'b0;
      match       <= '0;
      period      <= '0;
      ratio_log2  <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else if (clr) begin
      hist        <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      cand_ok     <= 1'b0;
      match       <= '0;
      period      <= '0;
      ratio_log2  <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      hist        <= synced;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cand        <= cand_nxt;
      cand_ok     <= cand_ok_nxt;
      match       <= match_nxt;
      period      <= period_nxt;
      ratio_log2  <= ratio_nxt;
      ratio_valid <= valid_nxt;
      locked      <= locked_nxt;
      lost        <= lost_nxt;
    end
  end

endmodule
